// File: rtl/dram_bank_responder.sv
// Device-side DRAM bank model: per-bank ACT/COL/PRE state machines with tRCD/tRP timing,
// row buffers written back on precharge, and read data returned at a fixed CAS latency.
module dram_bank_responder #(
   parameter int DATA_WIDTH   = 1,
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int T_RCD        = 2,
   parameter int T_CL         = 3,
   parameter int T_RP         = 2
) (
   input  logic                            clk,
   input  logic                            rst_b,
   input  logic [1:0]                      cmd,
   input  logic [$clog2(NUM_OF_BANKS)-1:0] cs,
   input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_addr,
   input  logic [$clog2(NUM_OF_COLS)-1:0]  col_addr,
   input  logic                            dram_we,
   input  logic [DATA_WIDTH-1:0]           dram_data_in,
   output logic [DATA_WIDTH-1:0]           dram_data_out,
   output logic                            dram_data_valid,
   output logic [NUM_OF_BANKS-1:0]         bank_ready,
   output logic                            cmd_err
);

   localparam int BANK_W = $clog2(NUM_OF_BANKS);
   localparam int ROW_W  = $clog2(NUM_OF_ROWS);
   localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int CNT_W  = $clog2(T_MAX + 1);

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_ACT = 2'b01,
      CMD_COL = 2'b10,
      CMD_PRE = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      BANK_IDLE,
      BANK_ACTIVATING,
      BANK_ACTIVE,
      BANK_PRECHARGING
   } bank_state_e;

   typedef logic [NUM_OF_COLS-1:0][DATA_WIDTH-1:0] row_t;

   bank_state_e           state_q    [NUM_OF_BANKS];
   bank_state_e           state_d    [NUM_OF_BANKS];
   logic [CNT_W-1:0]      cnt_q      [NUM_OF_BANKS];
   logic [CNT_W-1:0]      cnt_d      [NUM_OF_BANKS];
   logic [ROW_W-1:0]      open_row_q [NUM_OF_BANKS];
   row_t                  row_buf    [NUM_OF_BANKS];
   row_t                  mem        [NUM_OF_BANKS][NUM_OF_ROWS];

   logic [T_CL-1:0]       pipe_valid_q;
   logic [DATA_WIDTH-1:0] pipe_data_q [T_CL];

   cmd_e                  cmd_dec;
   bank_state_e           sel_state;
   logic [CNT_W-1:0]      sel_cnt;
   logic                  sel_idle;
   logic                  sel_active;
   logic                  do_act;
   logic                  do_wr;
   logic                  do_rd;
   logic                  do_pre;
   logic                  err;

   assign cmd_dec   = cmd_e'(cmd);
   assign sel_state = state_q[cs];
   assign sel_cnt   = cnt_q[cs];

   // A bank on the last edge of its timing window already accepts the command that window guards.
   assign sel_active = (sel_state == BANK_ACTIVE) ||
                       ((sel_state == BANK_ACTIVATING) && (sel_cnt <= CNT_W'(1)));
   assign sel_idle   = (sel_state == BANK_IDLE) ||
                       ((sel_state == BANK_PRECHARGING) && (sel_cnt <= CNT_W'(1)));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      do_act = 1'b0;
      do_wr  = 1'b0;
      do_rd  = 1'b0;
      do_pre = 1'b0;
      err    = 1'b0;
      case (cmd_dec)
         CMD_ACT: begin
            if (sel_idle) do_act = 1'b1;
            else          err    = 1'b1;
         end
         CMD_COL: begin
            if (sel_active) begin
               do_wr = dram_we;
               do_rd = !dram_we;
            end else begin
               err = 1'b1;
            end
         end
         CMD_PRE: begin
            if (sel_active)     do_pre = 1'b1;
            else if (!sel_idle) err    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = (cnt_q[b] != '0) ? cnt_q[b] - CNT_W'(1) : '0;
         case (state_q[b])
            BANK_ACTIVATING:  if (cnt_q[b] <= CNT_W'(1)) state_d[b] = BANK_ACTIVE;
            BANK_PRECHARGING: if (cnt_q[b] <= CNT_W'(1)) state_d[b] = BANK_IDLE;
            default: ;
         endcase
         if (cs == BANK_W'(b)) begin
            if (do_act) begin
               state_d[b] = BANK_ACTIVATING;
               cnt_d[b]   = CNT_W'(T_RCD);
            end else if (do_pre) begin
               state_d[b] = BANK_PRECHARGING;
               cnt_d[b]   = CNT_W'(T_RP);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int b = 0; b < NUM_OF_BANKS; b++) begin
            state_q[b]    <= BANK_IDLE;
            cnt_q[b]      <= '0;
            open_row_q[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_OF_BANKS; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
         if (do_act) open_row_q[cs] <= row_addr;
      end
   end

   // NOTE: storage arrays carry no reset; their contents are undefined until written.
   always_ff @(posedge clk) begin
      if (do_act) row_buf[cs]                  <= mem[cs][row_addr];
      if (do_wr)  row_buf[cs][col_addr]        <= dram_data_in;
      if (do_pre) mem[cs][open_row_q[cs]]      <= row_buf[cs];
   end

   // Read data is captured at the issuing edge, so a later write cannot disturb it.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pipe_valid_q    <= '0;
         for (int i = 0; i < T_CL; i++) pipe_data_q[i] <= '0;
         dram_data_valid <= 1'b0;
         dram_data_out   <= '0;
         cmd_err         <= 1'b0;
      end else begin
         pipe_valid_q[0] <= do_rd;
         if (do_rd) pipe_data_q[0] <= row_buf[cs][col_addr];
         for (int i = 1; i < T_CL; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_data_q[i]  <= pipe_data_q[i-1];
         end
         dram_data_valid <= pipe_valid_q[T_CL-1];
         if (pipe_valid_q[T_CL-1]) dram_data_out <= pipe_data_q[T_CL-1];
         cmd_err         <= err;
      end
   end

   always_comb begin
      bank_ready = '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
         bank_ready[b] = (state_q[b] == BANK_IDLE) || (state_q[b] == BANK_ACTIVE);
      end
   end

endmodule

// File: tb/tb_dram_bank_responder.sv
// Scoreboard bench for dram_bank_responder: a time-based bank model predicts errors, readiness
// and read data; a negedge monitor pops expected reads whenever the DUT presents valid data.
module tb_dram_bank_responder;

   localparam int DATA_WIDTH   = 1;
   localparam int NUM_OF_BANKS = 8;
   localparam int NUM_OF_ROWS  = 128;
   localparam int NUM_OF_COLS  = 8;
   localparam int T_RCD        = 2;
   localparam int T_CL         = 3;
   localparam int T_RP         = 2;
   localparam int BANK_W       = $clog2(NUM_OF_BANKS);
   localparam int ROW_W        = $clog2(NUM_OF_ROWS);
   localparam int COL_W        = $clog2(NUM_OF_COLS);
   localparam int MAX_EDGES    = 4096;

   localparam logic [1:0] C_NOP = 2'b00;
   localparam logic [1:0] C_ACT = 2'b01;
   localparam logic [1:0] C_COL = 2'b10;
   localparam logic [1:0] C_PRE = 2'b11;

   typedef enum int {S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING} mstate_e;

   typedef struct {
      int                    due;
      logic [DATA_WIDTH-1:0] data;
      bit                    known;
   } rd_t;

   logic                    clk = 1'b0;
   logic                    rst_b = 1'b0;
   logic [1:0]              cmd = C_NOP;
   logic [BANK_W-1:0]       cs = '0;
   logic [ROW_W-1:0]        row_addr = '0;
   logic [COL_W-1:0]        col_addr = '0;
   logic                    dram_we = 1'b0;
   logic [DATA_WIDTH-1:0]   dram_data_in = '0;
   logic [DATA_WIDTH-1:0]   dram_data_out;
   logic                    dram_data_valid;
   logic [NUM_OF_BANKS-1:0] bank_ready;
   logic                    cmd_err;

   dram_bank_responder #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_OF_BANKS(NUM_OF_BANKS), .NUM_OF_ROWS(NUM_OF_ROWS),
      .NUM_OF_COLS(NUM_OF_COLS), .T_RCD(T_RCD), .T_CL(T_CL), .T_RP(T_RP)
   ) dut (
      .clk(clk), .rst_b(rst_b), .cmd(cmd), .cs(cs), .row_addr(row_addr), .col_addr(col_addr),
      .dram_we(dram_we), .dram_data_in(dram_data_in), .dram_data_out(dram_data_out),
      .dram_data_valid(dram_data_valid), .bank_ready(bank_ready), .cmd_err(cmd_err)
   );

   initial forever #5 clk = ~clk;

   // Reference model: a bank is described by when it was last opened or closed.
   bit                    m_open      [NUM_OF_BANKS];
   int                    m_act_edge  [NUM_OF_BANKS];
   int                    m_pre_edge  [NUM_OF_BANKS];
   int                    m_row       [NUM_OF_BANKS];
   logic [DATA_WIDTH-1:0] m_mem       [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];
   bit                    m_mem_known [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];
   logic [DATA_WIDTH-1:0] m_buf       [NUM_OF_BANKS][NUM_OF_COLS];
   bit                    m_buf_known [NUM_OF_BANKS][NUM_OF_COLS];

   rd_t                     exp_q[$];
   bit                      exp_err   [MAX_EDGES];
   logic [NUM_OF_BANKS-1:0] exp_ready [MAX_EDGES];

   int stim_edge = 0;
   int mon_edge  = 0;
   int n_checks  = 0;
   int n_fails   = 0;

   logic [DATA_WIDTH-1:0] last_out   = '0;
   bit                    last_known = 1'b1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want,
                        input int at_edge);
      n_checks++;
      if (got !== want) begin
         n_fails++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, at_edge, got, want);
      end
   endtask

   function automatic mstate_e bank_state(input int b, input int e);
      if (m_open[b]) return (e >= m_act_edge[b] + T_RCD) ? S_ACTIVE : S_ACTIVATING;
      return (e >= m_pre_edge[b] + T_RP) ? S_IDLE : S_PRECHARGING;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
         m_open[b]     = 1'b0;
         m_pre_edge[b] = -100;
         m_act_edge[b] = -100;
      end
   endfunction

   // Drive one command, let it be sampled at the next edge, and record what that edge implies.
   task automatic step(input logic [1:0] c, input int b, input int r, input int col,
                       input bit we, input logic [DATA_WIDTH-1:0] din);
      bit                      err;
      mstate_e                 st;
      rd_t                     item;
      logic [NUM_OF_BANKS-1:0] rdy;
      cmd          = c;
      cs           = BANK_W'(b);
      row_addr     = ROW_W'(r);
      col_addr     = COL_W'(col);
      dram_we      = we;
      dram_data_in = din;
      @(posedge clk);
      stim_edge++;
      err = 1'b0;
      if (rst_b) begin
         st = bank_state(b, stim_edge);
         case (c)
            C_ACT: begin
               if (st == S_IDLE) begin
                  m_open[b]     = 1'b1;
                  m_act_edge[b] = stim_edge;
                  m_row[b]      = r;
                  for (int k = 0; k < NUM_OF_COLS; k++) begin
                     m_buf[b][k]       = m_mem[b][r][k];
                     m_buf_known[b][k] = m_mem_known[b][r][k];
                  end
               end else err = 1'b1;
            end
            C_COL: begin
               if (st == S_ACTIVE) begin
                  if (we) begin
                     m_buf[b][col]       = din;
                     m_buf_known[b][col] = 1'b1;
                  end else begin
                     item.due   = stim_edge + T_CL;
                     item.data  = m_buf[b][col];
                     item.known = m_buf_known[b][col];
                     exp_q.push_back(item);
                  end
               end else err = 1'b1;
            end
            C_PRE: begin
               if (st == S_ACTIVE) begin
                  for (int k = 0; k < NUM_OF_COLS; k++) begin
                     m_mem[b][m_row[b]][k]       = m_buf[b][k];
                     m_mem_known[b][m_row[b]][k] = m_buf_known[b][k];
                  end
                  m_open[b]     = 1'b0;
                  m_pre_edge[b] = stim_edge;
               end else if (st != S_IDLE) err = 1'b1;
            end
            default: ;
         endcase
      end
      for (int k = 0; k < NUM_OF_BANKS; k++) begin
         st     = bank_state(k, stim_edge);
         rdy[k] = (st == S_IDLE) || (st == S_ACTIVE);
      end
      if (stim_edge < MAX_EDGES) begin
         exp_err[stim_edge]   = err;
         exp_ready[stim_edge] = rdy;
      end
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(C_NOP, 0, 0, 0, 1'b0, '0);
   endtask

   // Assert reset between edges, hold it across two edges, release just after the second.
   task automatic pulse_reset();
      #2;
      rst_b = 1'b0;
      model_reset();
      nop(2);
      rst_b = 1'b1;
   endtask

   always @(posedge clk) mon_edge <= mon_edge + 1;

   always @(negedge clk) begin
      rd_t item;
      if (mon_edge > 0 && mon_edge < MAX_EDGES) begin
         if (!rst_b) begin
            last_out   = '0;
            last_known = 1'b1;
         end
         check("cmd_err", 64'(cmd_err), 64'(exp_err[mon_edge]), mon_edge);
         check("bank_ready", 64'(bank_ready), 64'(exp_ready[mon_edge]), mon_edge);
         if (dram_data_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'(dram_data_valid), 64'(0), mon_edge);
            end else begin
               item = exp_q.pop_front();
               check("valid_edge", 64'(mon_edge), 64'(item.due), mon_edge);
               if (item.known) check("read_data", 64'(dram_data_out), 64'(item.data), mon_edge);
               last_out   = item.data;
               last_known = item.known;
            end
         end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= mon_edge) begin
               item = exp_q.pop_front();
               check("missing_valid", 64'(dram_data_valid), 64'(1), mon_edge);
            end
            if (last_known) check("data_hold", 64'(dram_data_out), 64'(last_out), mon_edge);
         end
      end
   end

   initial begin
      int b;
      int r;
      int sel;
      model_reset();
      nop(3);
      rst_b = 1'b1;

      // Write then read through an opened row.
      step(C_ACT, 3, 5, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 3, 0, 2, 1'b1, 1'b1);
      step(C_COL, 3, 0, 2, 1'b0, '0);
      nop(3);

      // Write-back on precharge, reopen, and row isolation.
      step(C_PRE, 3, 0, 0, 1'b0, '0);
      nop(1);
      step(C_ACT, 3, 5, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 3, 0, 2, 1'b0, '0);
      nop(3);
      step(C_PRE, 3, 0, 0, 1'b0, '0);
      nop(1);
      step(C_ACT, 3, 6, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 3, 0, 2, 1'b1, 1'b0);
      step(C_PRE, 3, 0, 0, 1'b0, '0);
      nop(1);
      step(C_ACT, 3, 5, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 3, 0, 2, 1'b0, '0);
      nop(4);

      // Illegal commands: read to an idle bank, early COL, ACT to an open bank.
      step(C_COL, 1, 0, 0, 1'b0, '0);
      nop(1);
      step(C_ACT, 0, 1, 0, 1'b0, '0);
      step(C_COL, 0, 0, 0, 1'b0, '0);
      nop(2);
      step(C_ACT, 0, 1, 0, 1'b0, '0);
      nop(1);

      // Two banks interleaved with back-to-back reads.
      step(C_ACT, 1, 1, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 0, 0, 0, 1'b1, 1'b1);
      step(C_COL, 1, 0, 0, 1'b1, 1'b0);
      step(C_PRE, 0, 0, 0, 1'b0, '0);
      step(C_PRE, 1, 0, 0, 1'b0, '0);
      nop(1);
      step(C_ACT, 0, 1, 0, 1'b0, '0);
      step(C_ACT, 1, 1, 0, 1'b0, '0);
      nop(1);
      step(C_COL, 0, 0, 0, 1'b0, '0);
      step(C_COL, 1, 0, 0, 1'b0, '0);
      step(C_COL, 0, 0, 0, 1'b0, '0);
      nop(4);

      // Precharge of an idle bank is silent; precharge while activating is rejected.
      step(C_PRE, 5, 0, 0, 1'b0, '0);
      step(C_ACT, 5, 0, 0, 1'b0, '0);
      step(C_PRE, 5, 0, 0, 1'b0, '0);
      nop(2);

      // Reset with a read in flight.
      step(C_COL, 5, 0, 3, 1'b0, '0);
      pulse_reset();
      nop(6);

      // Randomized traffic over a few banks and rows so stored data gets reused.
      for (int i = 0; i < 1500; i++) begin
         b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_OF_BANKS - 1))
                                           : int'($urandom_range(0, 2));
         r   = int'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 99));
         if (i == 750) pulse_reset();
         if (sel < 25)      nop(1);
         else if (sel < 45) step(C_ACT, b, r, 0, 1'b0, '0);
         else if (sel < 85) step(C_COL, b, 0, int'($urandom_range(0, NUM_OF_COLS - 1)),
                                 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom));
         else               step(C_PRE, b, 0, 0, 1'b0, '0);
      end

      nop(T_CL + 4);
      check("reads_outstanding", 64'(exp_q.size()), 64'(0), stim_edge);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/dram_bank_responder.md
Name: dram_bank_responder

Overview:
Device-side responder for the DRAM controller's command interface. It models NUM_OF_BANKS independent banks, each with a storage array, one open row and a row buffer. It decodes NOP/ACT/COL/PRE commands, enforces tRCD/tCL/tRP timing and returns read data with fixed CAS latency. It sits opposite the controller: it consumes cmd/cs/address/data and drives the data and status back to the controller.

Parameters:
DATA_WIDTH, 1, bits per column
NUM_OF_BANKS, 8, number of banks
NUM_OF_ROWS, 128, rows per bank
NUM_OF_COLS, 8, columns per row
T_RCD, 2, edges from ACT to the earliest legal column command (>=1)
T_CL, 3, edges from a read command to data valid (>=1)
T_RP, 2, edges from PRE to the earliest legal ACT (>=1)

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
cmd  input  2  00 NOP, 01 ACT, 10 COL, 11 PRE
cs  input  $clog2(NUM_OF_BANKS)  target bank
row_addr  input  $clog2(NUM_OF_ROWS)  row, used by ACT only
col_addr  input  $clog2(NUM_OF_COLS)  column, used by COL only
dram_we  input  1  COL direction: 1 write, 0 read
dram_data_in  input  DATA_WIDTH  write data, sampled with the COL write
dram_data_out  output  DATA_WIDTH  read data
dram_data_valid  output  1  read data valid, one-cycle pulse per read
bank_ready  output  NUM_OF_BANKS  bit b is high when bank b is IDLE or ACTIVE
cmd_err  output  1  illegal-command pulse

Behaviour:
- Single clock, rst_b. Asynchronous active-low reset. At most one command per edge. Command fields are sampled at a rising edge E when cmd != NOP.
- Per-bank FSM:
  - IDLE -(ACT)-> ACTIVATING; counter loaded with T_RCD.
  - ACTIVATING -> ACTIVE when the counter reaches 0. A COL command is legal at edge E+T_RCD.
  - ACTIVE -(PRE)-> PRECHARGING; counter loaded with T_RP.
  - PRECHARGING -> IDLE so that ACT is legal at edge E+T_RP.
- ACT on an IDLE bank:
  - row_buf[cs] <= array[cs][row_addr]
  - open_row[cs] <= row_addr
- COL write on an ACTIVE bank: row_buf[cs][col_addr] <= dram_data_in at E. A later read of that column returns the new value.
- COL read on an ACTIVE bank:
  - row_buf[cs][col_addr] enters a T_CL-deep pipeline.
  - dram_data_out and dram_data_valid are driven for exactly the cycle following edge E+T_CL.
  - Back-to-back reads give back-to-back valids in issue order.
  - A write at E+1 does not alter a read issued at E.
- PRE on an ACTIVE bank: array[cs][open_row] <= row_buf[cs] (write-back), then PRECHARGING.
- PRE on an IDLE bank: legal no-op, no error.
- Illegal commands:
  - ACT to a non-IDLE bank.
  - COL to a non-ACTIVE bank.
  - PRE to an ACTIVATING or PRECHARGING bank.
  - Effect: command ignored, no state or storage change; cmd_err high for the single cycle after E.
- Banks are fully independent. Timing windows of different banks overlap freely.
- dram_data_out holds its last value when dram_data_valid is low. It is 0 after reset.
- bank_ready is decoded from the state registers (glitch-free, no combinational input path).
- Reset values: all banks IDLE, counters 0, read pipeline cleared, dram_data_valid=0, dram_data_out=0, cmd_err=0, bank_ready=all ones.
- Array and row buffers are not reset; contents are undefined until written.
- Reset mid-operation: in-flight reads are discarded and no valid appears after release. Open rows are lost without write-back.
- Counter width is $clog2(max(T_RCD,T_RP)+1). Counters saturate at 0.

Test Plan:
1. Default params, ACT b3 row5 at E0, COL write col2 data 1 at E2, COL read col2 at E3 -> dram_data_valid=1 with dram_data_out=1 in the cycle after E6; cmd_err stays 0.
2. Continue from 1: PRE b3 at E7, ACT b3 row5 at E9, read col2 at E11 -> data 1 after E14. Also write 0 into row6 col2 via its own ACT/write/PRE, then re-read row5 -> 1. Confirms write-back and row isolation.
3. Errors:
   - COL read to IDLE bank1 -> cmd_err pulse, no valid.
   - ACT b0 at E0, COL at E1 -> cmd_err at E2, bank_ready[0]=0 until ACTIVE.
   - ACT b0 again while ACTIVE -> cmd_err.
4. Interleave: ACT b0 at E0, ACT b1 at E1, reads b0,b1,b0 at E3,E4,E5 -> valids in consecutive cycles after E6,E7,E8 with the correct data order.
5. PRE to bank5 while IDLE -> no error, bank_ready[5]=1. PRE to bank5 during ACTIVATING -> cmd_err, and the bank still reaches ACTIVE on schedule.
6. Read issued at E0, rst_b low at E1 and released at E2 -> no dram_data_valid through E6, bank_ready=8'hFF, dram_data_out=0.
